lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Serial receive-end checker for the XNOR-feedback LFSR pseudo-random stream produced by the lfsr chains.
- Self-synchronises a local LFSR to the incoming bit stream, declares lock, then counts bit errors.
- Sits at the sink of a PRBS link under test, clocked by the same clk as the generator.
- Used for sizing and regression benches in place of the manual $display word dump.

Parameters:
- WIDTH, 10, LFSR length (number of shift stages).
- TAP, 7, inner tap stage (1-based); feedback is stage[TAP] XNOR stage[WIDTH].
- LOCK_CNT, 16, consecutive matching bits required to declare lock.
- LOSS_CNT, 8, consecutive mismatching bits, while locked, that drop lock.
- CNT_W, 16, error counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- din  input  1  received serial bit.
- din_valid  input  1  din is sampled only on clk edges with din_valid=1.
- clear_cnt  input  1  synchronous clear of err_count; lock state is unaffected.
- locked  output  1  checker is synchronised.
- err_pulse  output  1  one-cycle pulse when a locked compare mismatches.
- err_count  output  CNT_W  saturating count of locked mismatches.
- state_o  output  2  FSM state for debug: 0 SEED, 1 VERIFY, 2 LOCKED.

Behaviour:
- Reset (async assert, sync release):
  - shift register = 0, FSM = SEED.
  - locked=0, err_pulse=0, err_count=0, all internal counters = 0.
- Expected bit: exp = sr[TAP] XNOR sr[WIDTH]. sr[1] is the newest bit; the register shifts toward sr[WIDTH].
- Cycles with din_valid=0 hold all state. err_pulse is 0 on those cycles.
- SEED state:
  - Shift din into sr on each valid bit; count valid bits.
  - After WIDTH valid bits, check sr. If sr is all-ones (XNOR lock-up), restart the count and stay in SEED. Otherwise go to VERIFY with the match counter at 0.
- VERIFY state:
  - Compare din to exp, then shift din into sr (self-sync).
  - On a match, increment the match counter. The LOCK_CNT-th consecutive match moves to LOCKED and sets locked=1 on that same edge.
  - On a mismatch, go to SEED with the count at 0. No error is counted.
- LOCKED state:
  - Shift exp, not din, into sr (free-running), so a single line error is counted once.
  - On a mismatch: err_pulse=1 for that cycle; err_count increments, saturating at 2^CNT_W-1; the miss counter increments.
  - On a match, the miss counter clears.
  - When the miss counter reaches LOSS_CNT: go to SEED and drop locked on the same edge. That final mismatch is still counted.
- Lock latency from reset release with clean, continuous valid data: locked rises on the edge of the (WIDTH+LOCK_CNT)-th valid bit, i.e. bit 26 with default parameters.
- clear_cnt:
  - clear_cnt together with an error on the same cycle: clear wins, err_count=0; err_pulse still asserts.
  - clear_cnt has no effect on FSM state or locked.
- Reset mid-operation: immediate return to reset values regardless of state. No partial lock is retained.
- The stream is valid for any non-all-ones seed. The period is 2^WIDTH-1 only when the taps are maximal; the checker does not check maximality.

Decomposition:
- Shared package lfsr_pkg holds:
  - FSM state encoding constants (SEED=0, VERIFY=1, LOCKED=2).
  - Default WIDTH/TAP values, shared with the generator.
  - A function computing the XNOR feedback from a shift-register vector.
- One natural sub-module: lfsr_core. It holds the WIDTH-stage shift register with a load-source select (din or exp), hold/enable, and the exp output. It is reusable by a future parameterised generator.
- FSM, counters and error logic stay in lfsr_checker.

Test Plan:
- Clean lock: drive an LFSR(10,7) stream from seed 10'b0000000001, din_valid=1 continuously. Required: locked=1 on the edge of bit 26, state_o=2, err_count=0 after 1000 further bits.
- Single error: after lock, invert bit 200. Required: exactly one err_pulse, err_count=1, locked stays 1, no further errors.
- Loss of lock: after lock, drive constant din=0 for 8 bits where exp=1 on all of them. Required: err_count=8, locked falls on the 8th mismatch, state_o=0, relock occurs 26 valid bits after the stream resumes.
- Lock-up seed: drive all-ones for 40 bits. Required: state_o never leaves 0, locked=0; after switching to a valid stream, lock follows within 26+10 bits.
- Gapped valid: clean stream with din_valid toggling 1/0 every cycle. Required: lock at the 26th valid bit (clock 51 or 52), no errors, no err_pulse on invalid cycles.
- Clear and saturation:
  - With CNT_W=4, inject 20 isolated errors while locked: err_count holds at 15.
  - clear_cnt on an error cycle: err_count=0 and err_pulse=1.
  - Async reset mid-LOCKED: all outputs return to 0 immediately.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the XNOR-feedback LFSR generator/checker family:
// FSM encoding, default polynomial and the feedback function.
package lfsr_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 10;
  localparam int DEF_TAP   = 7;
  localparam int MAX_WIDTH = 64;

  // Stage n (1-based) lives at bit n-1; stage 1 is the newest bit.
  function automatic logic xnor_fb(input logic [MAX_WIDTH-1:0] sr,
                                   input int width, input int tap);
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
    a = sr >> (tap - 1);
    b = sr >> (width - 1);
    return ~(a[0] ^ b[0]);
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// WIDTH-stage XNOR LFSR shift register with selectable load source
// (external bit or its own feedback) and a shift enable.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAP   = DEF_TAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load_din,
  input  logic             din,
  output logic             exp,
  output logic [WIDTH-1:0] sr
);

  logic [WIDTH-1:0] sr_q;
  logic             nxt;

  assign exp = xnor_fb(MAX_WIDTH'(sr_q), WIDTH, TAP);
  assign nxt = load_din ? din : exp;
  assign sr  = sr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else if (en) begin
      sr_q <= {sr_q[WIDTH-2:0], nxt};
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-end PRBS checker: seeds a local LFSR from the line, verifies it,
// then free-runs while locked and counts mismatching bits.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int TAP      = DEF_TAP,
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state_o
);

  localparam int SEED_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_CNT + 1);

  state_t             state, state_nxt;
  logic [SEED_W-1:0]  seed_cnt, seed_nxt;
  logic [MATCH_W-1:0] match_cnt, match_nxt;
  logic [MISS_W-1:0]  miss_cnt, miss_nxt;
  logic [CNT_W-1:0]   err_q, err_nxt;
  logic               exp;
  logic               mismatch;
  logic               seed_ones;
  logic [WIDTH-1:0]   sr;

  // While locked the register regenerates its own sequence so one line
  // error cannot corrupt later expected bits.
  lfsr_core #(
    .WIDTH (WIDTH),
    .TAP   (TAP)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .en       (din_valid),
    .load_din (state != LOCKED),
    .din      (din),
    .exp      (exp),
    .sr       (sr)
  );

  assign mismatch  = din ^ exp;
  assign seed_ones = &{sr[WIDTH-2:0], din};

  always_comb begin
    state_nxt = state;
    seed_nxt  = seed_cnt;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    err_nxt   = err_q;
    err_pulse = 1'b0;
    if (din_valid) begin
      unique case (state)
        SEED: begin
          if (seed_cnt == SEED_W'(WIDTH - 1)) begin
            seed_nxt = '0;
            if (!seed_ones) begin
              state_nxt = VERIFY;
              match_nxt = '0;
            end
          end else begin
            seed_nxt = seed_cnt + 1'b1;
          end
        end
        VERIFY: begin
          if (mismatch) begin
            state_nxt = SEED;
            seed_nxt  = '0;
            match_nxt = '0;
          end else if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
            state_nxt = LOCKED;
            match_nxt = '0;
          end else begin
            match_nxt = match_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (mismatch) begin
            err_pulse = 1'b1;
            if (err_q != '1) err_nxt = err_q + 1'b1;
            if (miss_cnt == MISS_W'(LOSS_CNT - 1)) begin
              state_nxt = SEED;
              seed_nxt  = '0;
              miss_nxt  = '0;
            end else begin
              miss_nxt = miss_cnt + 1'b1;
            end
          end else begin
            miss_nxt = '0;
          end
        end
        default: state_nxt = SEED;
      endcase
    end
    if (clear_cnt) err_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEED;
      seed_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err_q     <= '0;
    end else begin
      state     <= state_nxt;
      seed_cnt  <= seed_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      err_q     <= err_nxt;
    end
  end

  assign locked    = (state == LOCKED);
  assign err_count = err_q;
  assign state_o   = state;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: LFSR(10,7) stream source plus a behavioural
// checker model; scenarios cover lock, errors, loss, lock-up, gaps, clear.
module tb_lfsr_checker;

  localparam int WIDTH    = 10;
  localparam int TAP      = 7;
  localparam int LOCK_CNT = 16;
  localparam int LOSS_CNT = 8;
  localparam int CNT_W    = 4;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic             clear_cnt = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [1:0]       state_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lfsr_checker #(
    .WIDTH    (WIDTH),
    .TAP      (TAP),
    .LOCK_CNT (LOCK_CNT),
    .LOSS_CNT (LOSS_CNT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .state_o   (state_o)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Stream source: history of emitted bits, index 0 = most recent.
  bit gq[WIDTH];

  function automatic void gen_seed_one();
    for (int i = 0; i < WIDTH; i++) gq[i] = 1'b0;
    gq[0] = 1'b1;
  endfunction

  function automatic bit gen_bit();
    bit b;
    b = !(gq[TAP-1] ^ gq[WIDTH-1]);
    for (int j = WIDTH - 1; j > 0; j--) gq[j] = gq[j-1];
    gq[0] = b;
    return b;
  endfunction

  function automatic bit next_ones(input int n);
    bit t[WIDTH];
    bit b;
    t = gq;
    for (int i = 0; i < n; i++) begin
      b = !(t[TAP-1] ^ t[WIDTH-1]);
      if (!b) return 1'b0;
      for (int j = WIDTH - 1; j > 0; j--) t[j] = t[j-1];
      t[0] = b;
    end
    return 1'b1;
  endfunction

  // Behavioural checker model: mstate 0 seeding, 1 verifying, 2 locked.
  bit msr[WIDTH];
  int mstate, mcnt, mmatch, mmiss, merr;
  bit m_pulse;

  function automatic void model_reset();
    for (int i = 0; i < WIDTH; i++) msr[i] = 1'b0;
    mstate = 0; mcnt = 0; mmatch = 0; mmiss = 0; merr = 0; m_pulse = 1'b0;
  endfunction

  function automatic void model_push(input bit b);
    for (int j = WIDTH - 1; j > 0; j--) msr[j] = msr[j-1];
    msr[0] = b;
  endfunction

  function automatic void model_step(input bit d, input bit v, input bit clr);
    bit e;
    bit ones;
    m_pulse = 1'b0;
    e = !(msr[TAP-1] ^ msr[WIDTH-1]);
    if (v) begin
      if (mstate == 0) begin
        model_push(d);
        mcnt++;
        if (mcnt == WIDTH) begin
          mcnt = 0;
          ones = 1'b1;
          for (int i = 0; i < WIDTH; i++) ones &= msr[i];
          if (!ones) begin mstate = 1; mmatch = 0; end
        end
      end else if (mstate == 1) begin
        model_push(d);
        if (d == e) begin
          mmatch++;
          if (mmatch == LOCK_CNT) begin mstate = 2; mmatch = 0; end
        end else begin
          mstate = 0; mcnt = 0; mmatch = 0;
        end
      end else begin
        model_push(e);
        if (d != e) begin
          m_pulse = 1'b1;
          if (merr < SAT) merr++;
          mmiss++;
          if (mmiss == LOSS_CNT) begin mstate = 0; mmiss = 0; mcnt = 0; end
        end else begin
          mmiss = 0;
        end
      end
    end
    if (clr) merr = 0;
  endfunction

  logic             obs_pulse, obs_locked;
  logic [1:0]       obs_state;
  logic [CNT_W-1:0] obs_err;
  logic [7:0]       exp_vec, act_vec;

  // One clock: drive at negedge, sample err_pulse before the edge and the
  // registered outputs 1 time unit after it.
  task automatic step(input bit d, input bit v, input bit clr);
    @(negedge clk);
    din = d; din_valid = v; clear_cnt = clr;
    model_step(d, v, clr);
    #1 obs_pulse = err_pulse;
    @(posedge clk);
    #1;
    obs_locked = locked; obs_state = state_o; obs_err = err_count;
    act_vec = {obs_locked, obs_state, obs_err, obs_pulse};
    exp_vec = {mstate == 2, 2'(mstate), CNT_W'(merr), m_pulse};
  endtask

  task automatic do_reset();
    @(negedge clk);
    din_valid = 1'b0; clear_cnt = 1'b0; reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if ({locked, state_o, err_count, err_pulse} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs actual=%b required=%b",
               {locked, state_o, err_count, err_pulse}, 8'h00);
    end
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_clean_lock();
    do_reset();
    gen_seed_one();
    for (int i = 1; i <= WIDTH + LOCK_CNT + 1000; i++) begin
      step(gen_bit(), 1'b1, 1'b0);
      vectors++;
      if (act_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL clean_track bit=%0d actual=%b required=%b", i, act_vec, exp_vec);
      end
      if (i == 25 || i == 26) begin
        vectors++;
        if (obs_locked !== (i == 26)) begin
          miscompares++;
          $display("FAIL lock_latency bit=%0d locked actual=%b required=%b", i, obs_locked, i == 26);
        end
      end
    end
    vectors++;
    if ({obs_state, obs_err} !== {2'd2, CNT_W'(0)}) begin
      miscompares++;
      $display("FAIL clean_final state/err actual=%0d/%0d required=2/0", obs_state, obs_err);
    end
  endtask

  task automatic test_single_error();
    int pulses = 0;
    for (int i = 1; i <= 400; i++) begin
      step(gen_bit() ^ (i == 200), 1'b1, 1'b0);
      pulses += obs_pulse;
      vectors++;
      if (act_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL single_track bit=%0d actual=%b required=%b", i, act_vec, exp_vec);
      end
    end
    vectors++;
    if (pulses != 1 || obs_err !== CNT_W'(1) || obs_locked !== 1'b1) begin
      miscompares++;
      $display("FAIL single_error pulses/err/locked actual=%0d/%0d/%b required=1/1/1",
               pulses, obs_err, obs_locked);
    end
  endtask

  task automatic test_loss_of_lock();
    int guard = 0;
    step(1'b0, 1'b0, 1'b1);
    while (!next_ones(LOSS_CNT) && guard < 3000) begin
      step(gen_bit(), 1'b1, 1'b0);
      guard++;
    end
    vectors++;
    if (guard >= 3000) begin
      miscompares++;
      $display("FAIL loss_setup no run of ones found actual=%0d required<3000", guard);
    end
    for (int i = 1; i <= LOSS_CNT; i++) begin
      void'(gen_bit());
      step(1'b0, 1'b1, 1'b0);
      vectors++;
      if (obs_locked !== (i < LOSS_CNT) || obs_err !== CNT_W'(i) || act_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL loss_run miss=%0d actual=%b required locked=%b err=%0d model=%b",
                 i, act_vec, i < LOSS_CNT, i, exp_vec);
      end
    end
    vectors++;
    if (obs_state !== 2'd0) begin
      miscompares++;
      $display("FAIL loss_state actual=%0d required=0", obs_state);
    end
    for (int i = 1; i <= WIDTH + LOCK_CNT; i++) begin
      step(gen_bit(), 1'b1, 1'b0);
      vectors++;
      if (obs_locked !== (i == WIDTH + LOCK_CNT) || act_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL relock bit=%0d actual=%b required locked=%b model=%b",
                 i, act_vec, i == WIDTH + LOCK_CNT, exp_vec);
      end
    end
  endtask

  task automatic test_lockup_seed();
    int lock_at = 0;
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b1, 1'b0);
      vectors++;
      if (obs_state !== 2'd0 || obs_locked !== 1'b0) begin
        miscompares++;
        $display("FAIL lockup_hold bit=%0d state/locked actual=%0d/%b required=0/0",
                 i, obs_state, obs_locked);
      end
    end
    for (int i = 1; i <= 2 * WIDTH + LOCK_CNT + 4; i++) begin
      step(gen_bit(), 1'b1, 1'b0);
      if (obs_locked === 1'b1 && lock_at == 0) lock_at = i;
      vectors++;
      if (act_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL lockup_track bit=%0d actual=%b required=%b", i, act_vec, exp_vec);
      end
    end
    vectors++;
    if (lock_at == 0 || lock_at > 2 * WIDTH + LOCK_CNT) begin
      miscompares++;
      $display("FAIL lockup_relock bit actual=%0d required=1..%0d", lock_at, 2 * WIDTH + LOCK_CNT);
    end
  endtask

  task automatic test_gapped_valid();
    int lock_cyc = 0;
    bit v;
    do_reset();
    gen_seed_one();
    for (int c = 1; c <= 120; c++) begin
      v = c[0];
      step(v ? gen_bit() : 1'($urandom), v, 1'b0);
      if (obs_locked === 1'b1 && lock_cyc == 0) lock_cyc = c;
      vectors++;
      if (act_vec !== exp_vec || (!v && obs_pulse !== 1'b0)) begin
        miscompares++;
        $display("FAIL gapped cyc=%0d actual=%b required=%b", c, act_vec, exp_vec);
      end
    end
    vectors++;
    if (lock_cyc != 51) begin
      miscompares++;
      $display("FAIL gapped_lock_cycle actual=%0d required=51", lock_cyc);
    end
  endtask

  task automatic test_saturation_clear();
    for (int e = 0; e < 20; e++) begin
      for (int k = 0; k < int'($urandom_range(3, 12)); k++) step(gen_bit(), 1'b1, 1'b0);
      step(gen_bit() ^ 1'b1, 1'b1, 1'b0);
      vectors++;
      if (act_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL sat_track err#%0d actual=%b required=%b", e, act_vec, exp_vec);
      end
    end
    vectors++;
    if (obs_err !== CNT_W'(SAT) || obs_locked !== 1'b1) begin
      miscompares++;
      $display("FAIL saturation err/locked actual=%0d/%b required=%0d/1", obs_err, obs_locked, SAT);
    end
    step(gen_bit(), 1'b1, 1'b0);
    step(gen_bit() ^ 1'b1, 1'b1, 1'b1);
    vectors++;
    if (obs_pulse !== 1'b1 || obs_err !== CNT_W'(0) || obs_locked !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_on_error pulse/err/locked actual=%b/%0d/%b required=1/0/1",
               obs_pulse, obs_err, obs_locked);
    end
  endtask

  task automatic test_random_errors();
    for (int i = 1; i <= 600; i++) begin
      step(gen_bit() ^ ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) != 0),
           ($urandom_range(0, 40) == 0));
      vectors++;
      if (act_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL random_track cyc=%0d actual=%b required=%b", i, act_vec, exp_vec);
      end
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (obs_locked !== 1'b1 && guard < 200) begin
      step(gen_bit(), 1'b1, 1'b0);
      guard++;
    end
    step(gen_bit() ^ 1'b1, 1'b1, 1'b0);
    vectors++;
    if (obs_locked !== 1'b1 || obs_err === CNT_W'(0)) begin
      miscompares++;
      $display("FAIL async_setup locked/err actual=%b/%0d required=1/nonzero", obs_locked, obs_err);
    end
    @(negedge clk);
    din_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({locked, state_o, err_count, err_pulse} !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset actual=%b required=%b",
               {locked, state_o, err_count, err_pulse}, 8'h00);
    end
    #1 reset = 1'b0;
    din_valid = 1'b0;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_of_lock();
    test_lockup_seed();
    test_gapped_valid();
    test_saturation_clear();
    test_random_errors();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
